// File: rtl/optsens_pkg.sv
// Shared register map, product ID and SPI transaction states for the optical sensor responder.
package optsens_pkg;

    localparam logic [6:0] ADDR_PRODUCT_ID  = 7'h00;
    localparam logic [6:0] ADDR_MOTION      = 7'h02;
    localparam logic [6:0] ADDR_DELTA_X     = 7'h03;
    localparam logic [6:0] ADDR_DELTA_Y     = 7'h04;
    localparam logic [6:0] ADDR_CONFIG      = 7'h0A;
    localparam logic [7:0] PRODUCT_ID_VALUE = 8'h17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } spi_state_t;

    // Signed 8-bit add that clamps at +127 / -128 instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [7:0] inc);
        logic signed [8:0] sum;
        sum = $signed({acc[7], acc}) + $signed({inc[7], inc});
        if (sum > 9'sd127) return 8'h7F;
        if (sum < -9'sd128) return 8'h80;
        return sum[7:0];
    endfunction

endpackage

// File: rtl/optsens_spi_shifter.sv
// SPI mode-3 front end: synchronisers, edge detection, receive bit counter and transmit shifter.
module optsens_spi_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sysclk,
    input  logic       select,
    input  logic       mosi,
    input  logic       clear,
    input  logic       tx_en,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       sel_high,
    output logic       sel_fall,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       miso
);

    logic [1:0] sck_sync;
    logic [1:0] sel_sync;
    logic [1:0] mosi_sync;
    logic       sck_prev;
    logic       sel_prev;
    logic       sck_rise;
    logic       sck_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;

    assign sck_rise  = sck_sync[1] & ~sck_prev;
    assign sck_fall  = ~sck_sync[1] & sck_prev;
    assign sel_high  = sel_sync[1];
    assign sel_fall  = ~sel_sync[1] & sel_prev;
    assign byte_done = sck_rise & ~clear & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, mosi_sync[1]};

    // Select resets to "asserted" so a select held low through reset never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync  <= 2'b11;
            sck_prev  <= 1'b1;
            sel_sync  <= 2'b00;
            sel_prev  <= 1'b0;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[0], sysclk};
            sck_prev  <= sck_sync[1];
            sel_sync  <= {sel_sync[0], select};
            sel_prev  <= sel_sync[1];
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else if (sck_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= {rx_shift[5:0], mosi_sync[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift <= 8'd0;
            miso     <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_shift <= tx_data;
            end else if (tx_en && sck_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (!tx_en) begin
                miso <= 1'b0;
            end else if (sck_fall) begin
                miso <= tx_shift[7];
            end
        end
    end

endmodule

// File: rtl/optical_sensor_responder.sv
// Optical motion sensor SPI slave: register file, motion accumulators and transaction FSM.
// Define OPTSENS_BURST_EN to stream auto-incrementing read bytes while select stays low.
module optical_sensor_responder
    import optsens_pkg::*;
(
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       sysclk,
    input  logic       select,
    input  logic       mosi,
    output logic       miso,
    input  logic       npd,
    input  logic       sensorrst,
    input  logic [7:0] delta_x_in,
    input  logic [7:0] delta_y_in,
    input  logic       delta_valid,
    output logic [7:0] config_out
);

`ifdef OPTSENS_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic       rst_n;
    spi_state_t state_q;
    spi_state_t state_d;
    logic [6:0] addr_q;
    logic [6:0] load_addr;
    logic       wr_q;
    logic       sel_high;
    logic       sel_fall;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       latch_addr;
    logic       cfg_write;
    logic       abort;
    logic       read_motion;
    logic [7:0] acc_x;
    logic [7:0] acc_y;
    logic [7:0] snap_x;
    logic [7:0] snap_y;
    logic       pending;
    logic [7:0] config_q;

    assign rst_n       = reset_reset_n & ~sensorrst;
    assign abort       = sel_high | ~npd;
    assign read_motion = tx_load & (load_addr == ADDR_MOTION);
    assign config_out  = config_q;

    optsens_spi_shifter u_shifter (
        .clk       (clk_clk),
        .rst_n     (rst_n),
        .sysclk    (sysclk),
        .select    (select),
        .mosi      (mosi),
        .clear     (state_q == ST_IDLE),
        .tx_en     ((state_q == ST_DATA) && !wr_q),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .sel_high  (sel_high),
        .sel_fall  (sel_fall),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .miso      (miso)
    );

    always_comb begin
        state_d    = state_q;
        tx_load    = 1'b0;
        latch_addr = 1'b0;
        load_addr  = addr_q;
        cfg_write  = 1'b0;
        case (state_q)
            ST_IDLE: if (sel_fall) state_d = ST_ADDR;
            ST_ADDR: if (byte_done) begin
                state_d    = ST_DATA;
                latch_addr = 1'b1;
                load_addr  = rx_byte[6:0];
                tx_load    = ~rx_byte[7];
            end
            ST_DATA: if (byte_done) begin
                if (wr_q) begin
                    cfg_write = (addr_q == ADDR_CONFIG);
                    state_d   = ST_HOLD;
                end else if (BURST_EN) begin
                    latch_addr = 1'b1;
                    load_addr  = addr_q + 7'd1;
                    tx_load    = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: state_d = ST_HOLD;
            default: state_d = ST_IDLE;
        endcase
        // Deselect or power-down wins over anything the current byte would have done.
        if (abort) begin
            state_d    = ST_IDLE;
            tx_load    = 1'b0;
            latch_addr = 1'b0;
            cfg_write  = 1'b0;
        end
    end

    always_comb begin
        case (load_addr)
            ADDR_PRODUCT_ID: tx_data = PRODUCT_ID_VALUE;
            ADDR_MOTION:     tx_data = {pending, 7'd0};
            ADDR_DELTA_X:    tx_data = snap_x;
            ADDR_DELTA_Y:    tx_data = snap_y;
            ADDR_CONFIG:     tx_data = config_q;
            default:         tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 7'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_addr) begin
                addr_q <= load_addr;
                if (state_q == ST_ADDR) wr_q <= rx_byte[7];
            end
        end
    end

    // A MOTION read snapshots and clears the accumulators; a coincident delta starts the new accumulation.
    always_ff @(posedge clk_clk) begin
        if (!rst_n) begin
            acc_x    <= 8'd0;
            acc_y    <= 8'd0;
            snap_x   <= 8'd0;
            snap_y   <= 8'd0;
            pending  <= 1'b0;
            config_q <= 8'd0;
        end else begin
            if (read_motion) begin
                snap_x  <= acc_x;
                snap_y  <= acc_y;
                acc_x   <= delta_valid ? delta_x_in : 8'd0;
                acc_y   <= delta_valid ? delta_y_in : 8'd0;
                pending <= delta_valid;
            end else if (delta_valid) begin
                acc_x   <= sat_add8(acc_x, delta_x_in);
                acc_y   <= sat_add8(acc_y, delta_y_in);
                pending <= 1'b1;
            end
            if (cfg_write) config_q <= rx_byte;
        end
    end

endmodule

// File: tb/tb_optical_sensor_responder.sv
// Scoreboard bench: a bit-banged SPI master pushes expected read bytes, a bus monitor pops and compares them.
module tb_optical_sensor_responder;

`ifdef OPTSENS_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk_clk;
    logic       reset_reset_n;
    logic       sysclk;
    logic       select;
    logic       mosi;
    logic       miso;
    logic       npd;
    logic       sensorrst;
    logic [7:0] delta_x_in;
    logic [7:0] delta_y_in;
    logic       delta_valid;
    logic [7:0] config_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    int         m_acc_x, m_acc_y, m_snap_x, m_snap_y;
    bit         m_pending;
    logic [7:0] m_config;

    optical_sensor_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sysclk        (sysclk),
        .select        (select),
        .mosi          (mosi),
        .miso          (miso),
        .npd           (npd),
        .sensorrst     (sensorrst),
        .delta_x_in    (delta_x_in),
        .delta_y_in    (delta_y_in),
        .delta_valid   (delta_valid),
        .config_out    (config_out)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_reset();
        m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0;
        m_pending = 1'b0; m_config = 8'h00;
    endtask

    task automatic model_byte(input logic [6:0] a, output logic [7:0] v);
        case (a)
            7'h00: v = 8'h17;
            7'h02: begin
                v = m_pending ? 8'h80 : 8'h00;
                m_snap_x = m_acc_x; m_snap_y = m_acc_y;
                m_acc_x = 0; m_acc_y = 0; m_pending = 1'b0;
            end
            7'h03: v = 8'(m_snap_x);
            7'h04: v = 8'(m_snap_y);
            7'h0A: v = m_config;
            default: v = 8'h00;
        endcase
    endtask

    // Mode 3 master: data changes on the falling edge, slave samples on the rising edge, 16-clock period.
    task automatic apply_stimulus(input logic [7:0] addr_byte, input logic [7:0] wdata,
                                  input int ndata, input int abort_bits);
        int nbits;
        logic [7:0] cur;
        nbits = (abort_bits > 0) ? abort_bits : 8 * (ndata + 1);
        wait_clk(1);
        select = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            cur = (i < 8) ? addr_byte : wdata;
            sysclk = 1'b0;
            mosi = cur[7 - (i % 8)];
            wait_clk(8);
            sysclk = 1'b1;
            wait_clk(8);
        end
        select = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        logic [7:0] v;
        logic [6:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 7'(i);
            if (!npd) v = 8'h00;
            else if (i == 0 || BURST) model_byte(ai, v);
            else v = 8'h00;
            exp_q.push_back(v);
        end
        apply_stimulus({1'b0, a}, 8'h00, n, 0);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int n);
        if (npd && a == 7'h0A) m_config = d;
        apply_stimulus({1'b1, a}, d, n, 0);
        check_output("config_out", config_out, m_config);
    endtask

    task automatic apply_delta(input logic [7:0] dx, input logic [7:0] dy);
        delta_x_in = dx;
        delta_y_in = dy;
        delta_valid = 1'b1;
        wait_clk(1);
        delta_valid = 1'b0;
        wait_clk(1);
        m_acc_x = clamp8(m_acc_x + int'($signed(dx)));
        m_acc_y = clamp8(m_acc_y + int'($signed(dy)));
        m_pending = 1'b1;
    endtask

    // Bus monitor: first byte after select is the address, each later byte of a read is scored.
    int         mon_cnt = 0;
    logic [7:0] mon_mosi = 8'h00;
    logic [7:0] mon_miso = 8'h00;
    bit         mon_write = 1'b0;

    always @(posedge sysclk or posedge select) begin
        if (select === 1'b1) begin
            mon_cnt = 0;
        end else begin
            mon_mosi = {mon_mosi[6:0], mosi};
            mon_miso = {mon_miso[6:0], miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_write = mon_mosi[7];
                check_output("addr_phase_miso", mon_miso, 8'h00);
            end else if (mon_cnt % 8 == 0 && !mon_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL read_byte: got 0x%02h, expected no byte (scoreboard empty)", mon_miso);
                end else begin
                    check_output("read_byte", mon_miso, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk_clk);
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got cycle budget exhausted, expected end of test");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] rd, rdy;
        logic [6:0] ra;
        reset_reset_n = 1'b0; select = 1'b1; sysclk = 1'b1; mosi = 1'b0;
        npd = 1'b1; sensorrst = 1'b0; delta_valid = 1'b0;
        delta_x_in = 8'h00; delta_y_in = 8'h00;
        model_reset();
        wait_clk(4);
        check_output("reset_config_out", config_out, 8'h00);
        check_output("reset_miso", {7'd0, miso}, 8'h00);
        reset_reset_n = 1'b1;
        wait_clk(4);

        $display("[TB] directed: product id, config write, saturation");
        do_read(7'h00, 1);
        do_write(7'h0A, 8'h5C, 1);
        do_read(7'h0A, 1);
        repeat (3) apply_delta(8'd100, 8'd0);
        do_read(7'h02, 1);
        do_read(7'h03, 1);
        do_read(7'h02, 1);

        $display("[TB] directed: aborted address, power-down, resets");
        apply_stimulus(8'h8A, 8'h00, 0, 5);
        check_output("abort_config_out", config_out, m_config);
        do_read(7'h00, 1);
        apply_delta(8'd3, 8'hFE);
        do_read(7'h02, 3);
        npd = 1'b0;
        do_read(7'h00, 1);
        apply_delta(8'd5, 8'd7);
        npd = 1'b1;
        wait_clk(4);
        do_read(7'h02, 1);
        do_read(7'h03, 1);
        do_write(7'h03, 8'h55, 2);
        do_read(7'h03, 1);
        do_read(7'h7F, 2);
        do_write(7'h0A, 8'h33, 1);
        apply_delta(8'h90, 8'h10);
        sensorrst = 1'b1;
        wait_clk(2);
        sensorrst = 1'b0;
        model_reset();
        check_output("sensorrst_config_out", config_out, 8'h00);
        do_read(7'h02, 1);
        do_write(7'h0A, 8'hA5, 1);
        reset_reset_n = 1'b0;
        wait_clk(2);
        reset_reset_n = 1'b1;
        model_reset();
        check_output("reset_pulse_config_out", config_out, 8'h00);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 3)) begin
                    rd = 8'($urandom_range(0, 255));
                    rdy = 8'($urandom_range(0, 255));
                    apply_delta(rd, rdy);
                end
                1: begin
                    case ($urandom_range(0, 5))
                        0: ra = 7'h00;
                        1: ra = 7'h02;
                        2: ra = 7'h03;
                        3: ra = 7'h04;
                        4: ra = 7'h0A;
                        default: ra = 7'($urandom_range(0, 127));
                    endcase
                    do_read(ra, $urandom_range(1, 3));
                end
                2: begin
                    case ($urandom_range(0, 3))
                        0, 1: ra = 7'h0A;
                        2: ra = 7'h03;
                        default: ra = 7'($urandom_range(0, 127));
                    endcase
                    do_write(ra, 8'($urandom_range(0, 255)), $urandom_range(1, 2));
                end
                default: do_read(7'h02, 3);
            endcase
        end

        wait_clk(20);
        check_output("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/optical_sensor_responder.md
OPTICAL_SENSOR_RESPONDER -- requirements
Module: optical_sensor_responder

Interface
REQ-001 SHALL have port: clk_clk  input  1  single fabric clock; all logic on its rising edge.
REQ-002 SHALL have port: reset_reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: sysclk  input  1  SPI clock from master; idles high (mode 3).
REQ-004 SHALL have port: select  input  1  chip select, active-low.
REQ-005 SHALL have port: mosi  input  1  serial data from master, MSB first.
REQ-006 SHALL have port: miso  output  1  serial data to master, MSB first.
REQ-007 SHALL have port: npd  input  1  power-down, active-low.
REQ-008 SHALL have port: sensorrst  input  1  sensor reset, active-high.
REQ-009 SHALL have port: delta_x_in  input  8  signed X motion increment.
REQ-010 SHALL have port: delta_y_in  input  8  signed Y motion increment.
REQ-011 SHALL have port: delta_valid  input  1  one-cycle strobe qualifying delta_x_in/delta_y_in.
REQ-012 SHALL have port: config_out  output  8  current CONFIG register contents.

Function
REQ-013 SHALL pass sysclk, select, mosi through 2-flop synchronisers and detect edges in the clk_clk domain; sysclk high/low phases SHALL each be ≥4 clk_clk cycles.
REQ-014 SHALL sample mosi on synchronised sysclk rising edge and update miso on falling edge.
REQ-015 SHALL implement FSM IDLE -> ADDR (8 bits) -> DATA (8 bits) -> HOLD; any select deassertion returns to IDLE from any state in the next cycle, discarding a partial byte.
REQ-016 SHALL interpret address byte bit7 as write (1) / read (0), bits6:0 as register address.
REQ-017 SHALL, on read, load the register value into the miso shifter at ADDR completion, with first data bit on the next sysclk falling edge.
REQ-018 SHALL, on write, commit the data byte only at the 8th DATA rising edge; writes to read-only/unmapped addresses are ignored.
REQ-019 SHALL map: 0x00 PRODUCT_ID = 0x17 RO; 0x02 MOTION RO, bit7 = motion pending; 0x03 DELTA_X RO; 0x04 DELTA_Y RO; 0x0A CONFIG RW; others read 0x00.
REQ-020 SHALL accumulate delta_valid increments into 8-bit signed DX/DY with saturation at +127/-128 and set motion pending.
REQ-021 SHALL, on reading MOTION, snapshot DX/DY into DELTA_X/DELTA_Y and clear accumulators and pending in the same cycle; a simultaneous delta_valid SHALL become the new accumulator value.
REQ-022 SHALL, when npd = 0, hold miso = 0, ignore SPI traffic (FSM in IDLE), and keep accumulating deltas.
REQ-023 SHALL drive miso = 0 in IDLE and ADDR.

Reset
REQ-024 SHALL, on reset_reset_n = 0 or sensorrst = 1 at a clock edge: FSM IDLE, miso 0, accumulators/snapshots 0, pending 0, CONFIG 0x00 (config_out = 0x00).
REQ-025 SHALL abort an in-flight transaction on reset; the next transaction requires a fresh select falling edge.

Configuration
REQ-026 SHALL honour macro OPTSENS_BURST_EN.
REQ-027 With OPTSENS_BURST_EN defined: after a read DATA byte with select still low, address auto-increments (wrap 0x7F -> 0x00) and further bytes stream; reading MOTION in burst SHALL snapshot before DELTA_X/DELTA_Y are shifted.
REQ-028 Without OPTSENS_BURST_EN: bytes after the first DATA byte return 0x00 and write bytes are ignored (HOLD until deselect).

Structure
REQ-029 SHALL place register address constants, PRODUCT_ID value, and FSM state enum in shared package optsens_pkg.
REQ-030 SHALL implement the SPI edge/shift logic in sub-module optsens_spi_shifter; register file and accumulators in the top.

Verification
REQ-031 Read 0x00 (sysclk period 16 clk) -> miso shifts 0x17.
REQ-032 Write 0x8A,0x5C then read 0x0A -> returns 0x5C; config_out = 0x5C.
REQ-033 Three delta_valid with dx=+100 -> read 0x02 gives 0x80, then 0x03 gives 0x7F (saturated); second 0x02 read gives 0x00.
REQ-034 Deassert select after 5 address bits, then read 0x00 -> 0x17, no spurious write.
REQ-035 npd = 0 during read of 0x00 -> miso stays 0; sensorrst pulse after CONFIG write -> config_out 0x00.
REQ-036 With OPTSENS_BURST_EN, read 0x02 and hold select for 3 bytes after dx=+3, dy=-2 -> 0x80, 0x03, 0xFE; without it -> 0x80, 0x00, 0x00.
